// File: rtl/rotary_paddle.sv
// Rotary encoder front end: sync, debounce, quadrature decode, saturated paddle position.
// Optional macro ROTARY_ACCEL_EN: detents arriving close together move 4*STEP.
module rotary_paddle #(
    parameter int unsigned DEBOUNCE_CYCLES = 25000,
    parameter logic [9:0]  PADDLE_MIN      = 10'd0,
    parameter logic [9:0]  PADDLE_MAX      = 10'd416,
    parameter logic [9:0]  INIT_POS        = 10'd208,
    parameter logic [9:0]  STEP            = 10'd8
) (
    input  logic       clk25,
    input  logic       reset,
    input  logic       rota,
    input  logic       rotb,
    output logic [9:0] paddle_pos,
    output logic       step_up,
    output logic       step_dn,
    output logic       seq_err
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0] STEP_W   = {1'b0, STEP};
    localparam logic [10:0] MIN_W    = {1'b0, PADDLE_MIN};
    localparam logic [10:0] MAX_W    = {1'b0, PADDLE_MAX};

    // Bit 1 carries phase A, bit 0 phase B throughout.
    logic [1:0]       sync1, sync2;
    logic [1:0]       filt;
    logic [CNT_W-1:0] db_cnt [2];

    logic [1:0]        prev;
    logic signed [2:0] sub_cnt;
    logic signed [3:0] sub_ext, sub_nxt;
    logic              fwd_c, rev_c, jump_c;
    logic              up_c, dn_c;
    logic [10:0]       move_c, pos_w, sum_c;
    logic [9:0]        pos_nxt_c;

    always_ff @(posedge clk25) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {rota, rotb};
            sync2 <= sync1;
        end
    end

    // Each phase must hold its new value for DEBOUNCE_CYCLES before it is accepted.
    always_ff @(posedge clk25) begin
        if (reset) begin
            filt      <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
    always_comb begin
        fwd_c  = 1'b0;
        rev_c  = 1'b0;
        jump_c = ((prev ^ filt) == 2'b11);
        unique case (prev)
            2'b00: begin fwd_c = (filt == 2'b10); rev_c = (filt == 2'b01); end
            2'b10: begin fwd_c = (filt == 2'b11); rev_c = (filt == 2'b00); end
            2'b11: begin fwd_c = (filt == 2'b01); rev_c = (filt == 2'b10); end
            2'b01: begin fwd_c = (filt == 2'b00); rev_c = (filt == 2'b11); end
            default: ;
        endcase

        sub_ext = {sub_cnt[2], sub_cnt};
        sub_nxt = sub_ext;
        up_c    = 1'b0;
        dn_c    = 1'b0;
        if (jump_c) begin
            sub_nxt = 4'sd0;
        end else if (fwd_c) begin
            sub_nxt = sub_ext + 4'sd1;
        end else if (rev_c) begin
            sub_nxt = sub_ext - 4'sd1;
        end
        // Landing on 00 ends a detent; only a full four-step run counts.
        if (!jump_c && (fwd_c || rev_c) && filt == 2'b00) begin
            up_c    = (sub_nxt == 4'sd4);
            dn_c    = (sub_nxt == -4'sd4);
            sub_nxt = 4'sd0;
        end
    end

`ifdef ROTARY_ACCEL_EN
    localparam logic [10:0] STEP_FAST = STEP_W << 2;
    logic [19:0] acc_cnt;
    logic        acc_armed;

    // Acceleration needs a previous step since reset to measure against.
    always_ff @(posedge clk25) begin
        if (reset) begin
            acc_cnt   <= '0;
            acc_armed <= 1'b0;
        end else if (up_c || dn_c) begin
            acc_cnt   <= '0;
            acc_armed <= 1'b1;
        end else if (acc_cnt != '1) begin
            acc_cnt <= acc_cnt + 20'(1);
        end
    end

    assign move_c = (acc_armed && !acc_cnt[19]) ? STEP_FAST : STEP_W;
`else
    assign move_c = STEP_W;
`endif

    assign pos_w = {1'b0, paddle_pos};
    assign sum_c = pos_w + move_c;

    always_comb begin
        pos_nxt_c = paddle_pos;
        if (up_c) begin
            pos_nxt_c = (sum_c > MAX_W) ? PADDLE_MAX : sum_c[9:0];
        end else if (dn_c) begin
            pos_nxt_c = (pos_w < MIN_W + move_c) ? PADDLE_MIN : 10'(pos_w - move_c);
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            prev       <= 2'b00;
            sub_cnt    <= 3'sd0;
            paddle_pos <= INIT_POS;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prev       <= filt;
            sub_cnt    <= sub_nxt[2:0];
            paddle_pos <= pos_nxt_c;
            step_up    <= up_c;
            step_dn    <= dn_c;
            seq_err    <= jump_c;
        end
    end

endmodule

// File: tb/tb_rotary_paddle.sv
// Directed bench for rotary_paddle with a short debounce window.
module tb_rotary_paddle;

    logic       clk25;
    logic       reset;
    logic       rota;
    logic       rotb;
    logic [9:0] paddle_pos;
    logic       step_up;
    logic       step_dn;
    logic       seq_err;

    int checks   = 0;
    int failures = 0;
    int n_up     = 0;
    int n_dn     = 0;
    int n_err    = 0;
    int n_clash  = 0;
    int up0, dn0, err0;

    rotary_paddle #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk25      (clk25),
        .reset      (reset),
        .rota       (rota),
        .rotb       (rotb),
        .paddle_pos (paddle_pos),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .seq_err    (seq_err)
    );

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    // Pulse tally sampled mid-cycle.
    always @(negedge clk25) begin
        if (step_up) n_up++;
        if (step_dn) n_dn++;
        if (seq_err) n_err++;
        if ((step_up && step_dn) || (seq_err && (step_up || step_dn))) n_clash++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input int cyc);
        rota = a;
        rotb = b;
        repeat (cyc) @(posedge clk25);
        #1;
    endtask

    task automatic cw_detent();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
    endtask

    task automatic ccw_detent();
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
    endtask

    task automatic snap();
        up0  = n_up;
        dn0  = n_dn;
        err0 = n_err;
    endtask

    initial begin
        reset = 1'b1;
        rota  = 1'b0;
        rotb  = 1'b0;
        repeat (3) @(posedge clk25);
        #1;
        check("reset_pos", int'(paddle_pos), 208);
        check("reset_up", int'(step_up), 0);
        check("reset_dn", int'(step_dn), 0);
        check("reset_err", int'(seq_err), 0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 10);

        snap();
        cw_detent();
        check("cw_up", n_up - up0, 1);
        check("cw_dn", n_dn - dn0, 0);
        check("cw_err", n_err - err0, 0);
        check("cw_pos", int'(paddle_pos), 216);

        snap();
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 15);
        check("glitch_pulses", (n_up - up0) + (n_dn - dn0) + (n_err - err0), 0);
        check("glitch_pos", int'(paddle_pos), 216);

        snap();
        for (int i = 0; i < 26; i++) ccw_detent();
        check("ccw26_pos", int'(paddle_pos), 8);
        ccw_detent();
        check("ccw27_pos", int'(paddle_pos), 0);
        for (int i = 27; i < 60; i++) ccw_detent();
        check("ccw60_pos", int'(paddle_pos), 0);
        check("ccw60_dn", n_dn - dn0, 60);
        check("ccw60_up", n_up - up0, 0);

        snap();
        cw_detent();
        check("cw_from_min", int'(paddle_pos), 8);
        for (int i = 1; i < 52; i++) cw_detent();
        check("cw52_pos", int'(paddle_pos), 416);
        for (int i = 52; i < 60; i++) cw_detent();
        check("cw60_pos", int'(paddle_pos), 416);
        check("cw60_up", n_up - up0, 60);
        check("cw60_err", n_err - err0, 0);

        snap();
        drive(1'b1, 1'b1, 10);
        check("jump_err", n_err - err0, 1);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
        check("jump_err_once", n_err - err0, 1);
        check("jump_nostep", (n_up - up0) + (n_dn - dn0), 0);
        check("jump_pos", int'(paddle_pos), 416);

        snap();
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        check("partial_pulses", (n_up - up0) + (n_dn - dn0) + (n_err - err0), 0);

        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        reset = 1'b1;
        drive(1'b0, 1'b0, 3);
        reset = 1'b0;
        check("midrst_pos", int'(paddle_pos), 208);
        snap();
        drive(1'b0, 1'b0, 10);
        check("midrst_err", n_err - err0, 0);
        cw_detent();
        check("midrst_up", n_up - up0, 1);
        check("midrst_pos_after", int'(paddle_pos), 216);

`ifdef ROTARY_ACCEL_EN
        reset = 1'b1;
        drive(1'b0, 1'b0, 3);
        reset = 1'b0;
        drive(1'b0, 1'b0, 10);
        cw_detent();
        check("accel_first", int'(paddle_pos), 216);
        drive(1'b0, 1'b0, 1000);
        cw_detent();
        check("accel_fast", int'(paddle_pos), 248);
        drive(1'b0, 1'b0, (1 << 19) + 10);
        cw_detent();
        check("accel_slow", int'(paddle_pos), 256);
`endif

        check("no_clash", n_clash, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
